// File: rtl/apb_splitter.sv
// apb_splitter: APB4 1-to-N splitter with registered decode, local decode-error and timeout responses.
module apb_splitter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLV = 4,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_MASK = '0,
  parameter int TIMEOUT = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          s_PSEL,
  input  logic                          s_PENABLE,
  input  logic                          s_PWRITE,
  input  logic [ADDR_WIDTH-1:0]         s_PADDR,
  input  logic [DATA_WIDTH-1:0]         s_PWDATA,
  input  logic [DATA_WIDTH/8-1:0]       s_PSTRB,
  output logic                          s_PREADY,
  output logic                          s_PSLVERR,
  output logic [DATA_WIDTH-1:0]         s_PRDATA,
  output logic [NUM_SLV-1:0]            m_PSEL,
  output logic                          m_PENABLE,
  output logic                          m_PWRITE,
  output logic [ADDR_WIDTH-1:0]         m_PADDR,
  output logic [DATA_WIDTH-1:0]         m_PWDATA,
  output logic [DATA_WIDTH/8-1:0]       m_PSTRB,
  input  logic [NUM_SLV-1:0]            m_PREADY,
  input  logic [NUM_SLV-1:0]            m_PSLVERR,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] m_PRDATA
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DECERR, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic write_q, write_d, err_q, err_d;
  logic [3:0] idx_q, idx_d, hit_idx;
  logic [7:0] cnt_q, cnt_d;
  logic hit, sel_ready, sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  // Descending scan so the lowest matching port is the one left standing.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    sel_ready = 1'b0;
    sel_err = 1'b0;
    sel_rdata = '0;
    for (int k = NUM_SLV - 1; k >= 0; k--) begin
      if ((s_PADDR & SLV_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        hit_idx = 4'(k);
      end
      if (idx_q == 4'(k)) begin
        sel_ready = m_PREADY[k];
        sel_err = m_PSLVERR[k];
        sel_rdata = m_PRDATA[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    strb_d = strb_q;
    write_d = write_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (s_PSEL && !s_PENABLE) begin
        addr_d = s_PADDR;
        wdata_d = s_PWDATA;
        strb_d = s_PSTRB;
        write_d = s_PWRITE;
        idx_d = hit_idx;
        state_d = hit ? SETUP : DECERR;
      end
      SETUP: begin
        cnt_d = '0;
        state_d = ACCESS;
      end
      ACCESS: if (sel_ready) begin
        rdata_d = write_q ? '0 : sel_rdata;
        err_d = sel_err;
        state_d = RESP;
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        rdata_d = '0;
        err_d = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      DECERR: begin
        rdata_d = '0;
        err_d = 1'b1;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      write_q <= 1'b0;
      idx_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      strb_q <= strb_d;
      write_q <= write_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  // Outputs decode straight from registers so an async reset clears them immediately.
  always_comb begin
    for (int k = 0; k < NUM_SLV; k++)
      m_PSEL[k] = (state_q == SETUP || state_q == ACCESS) && idx_q == 4'(k);
    m_PENABLE = state_q == ACCESS;
    s_PREADY = state_q == RESP && s_PSEL;
    s_PSLVERR = s_PREADY && err_q;
    s_PRDATA = s_PREADY ? rdata_q : '0;
  end
  assign m_PADDR = addr_q;
  assign m_PWRITE = write_q;
  assign m_PWDATA = wdata_q;
  assign m_PSTRB = strb_q;
endmodule

// File: tb/tb_apb_splitter.sv
// tb_apb_splitter: randomized transfers against a latency/response model of the splitter, plus directed map, timeout and reset cases.
module tb_apb_splitter;
  localparam int TMO = 16;
  localparam logic [127:0] BASE = {32'h2000, 32'h3000, 32'h1000, 32'h2000};
  localparam logic [127:0] MASK = {32'hFF00, 32'hF000, 32'hF000, 32'hF000};
  logic PCLK = 1'b0, PRESET = 1'b1;
  logic s_PSEL = 1'b0, s_PENABLE = 1'b0, s_PWRITE = 1'b0;
  logic [31:0] s_PADDR = '0, s_PWDATA = '0;
  logic [3:0] s_PSTRB = '0;
  logic s_PREADY, s_PSLVERR, m_PENABLE, m_PWRITE;
  logic [31:0] s_PRDATA, m_PADDR, m_PWDATA;
  logic [3:0] m_PSEL, m_PSTRB, m_PREADY, m_PSLVERR;
  logic [127:0] m_PRDATA;
  apb_splitter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLV(4), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE),
    .s_PADDR(s_PADDR), .s_PWDATA(s_PWDATA), .s_PSTRB(s_PSTRB), .s_PREADY(s_PREADY),
    .s_PSLVERR(s_PSLVERR), .s_PRDATA(s_PRDATA), .m_PSEL(m_PSEL), .m_PENABLE(m_PENABLE),
    .m_PWRITE(m_PWRITE), .m_PADDR(m_PADDR), .m_PWDATA(m_PWDATA), .m_PSTRB(m_PSTRB),
    .m_PREADY(m_PREADY), .m_PSLVERR(m_PSLVERR), .m_PRDATA(m_PRDATA));
  always #5 PCLK = ~PCLK;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;
  // Completer models: port k answers after wait_cfg[k] extra ACCESS cycles (>= TMO means hung).
  int wait_cfg [4];
  int acc_cnt [4];
  logic [31:0] rd_val [4];
  logic [3:0] err_cfg = '0;
  always @(posedge PCLK)
    for (int k = 0; k < 4; k++) acc_cnt[k] <= (m_PSEL[k] && m_PENABLE) ? acc_cnt[k] + 1 : 0;
  always_comb begin
    m_PREADY = '0;
    m_PRDATA = '0;
    for (int k = 0; k < 4; k++) begin
      m_PREADY[k] = m_PSEL[k] && m_PENABLE && acc_cnt[k] >= wait_cfg[k];
      m_PRDATA[k*32 +: 32] = rd_val[k];
    end
  end
  assign m_PSLVERR = err_cfg;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < 4; k++) if ((a & MASK[k*32 +: 32]) == BASE[k*32 +: 32]) return k;
    return -1;
  endfunction
  // Expected transfer: cycle t counts from the cycle after the setup is sampled.
  bit active = 0, mon_en = 0;
  int t0, e_port, e_lat, obs_lat;
  logic e_err, e_wr, obs_err;
  logic [31:0] e_rdata, e_addr, e_wdata, obs_rdata;
  logic [3:0] e_strb;
  always @(negedge PCLK) if (mon_en) begin
    int t;
    bit hit;
    t = cyc - t0;
    hit = e_port >= 0;
    if (active) begin
      chk("m_psel", m_PSEL, (hit && t >= 1 && t < e_lat) ? (4'b1 << e_port) : 4'b0);
      chk("m_penable", m_PENABLE, hit && t >= 2 && t < e_lat);
      chk("s_pready", s_PREADY, t == e_lat);
      chk("s_pslverr", s_PSLVERR, t == e_lat ? e_err : 1'b0);
      chk("s_prdata", s_PRDATA, t == e_lat ? e_rdata : 32'h0);
      chk("m_paddr", m_PADDR, e_addr);
      chk("m_pwrite", m_PWRITE, e_wr);
      chk("m_pwdata", m_PWDATA, e_wdata);
      chk("m_pstrb", m_PSTRB, e_strb);
    end else begin
      chk("idle_psel", m_PSEL, 4'b0);
      chk("idle_penable", m_PENABLE, 1'b0);
      chk("idle_pready", s_PREADY, 1'b0);
      chk("idle_pslverr", s_PSLVERR, 1'b0);
      chk("idle_prdata", s_PRDATA, 32'h0);
    end
  end
  // Called #1 after a rising edge; returns #1 after the edge that ends RESP.
  task automatic do_xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    bit seen = 0;
    e_port = decode(a);
    e_addr = a;
    e_wr = w;
    e_wdata = d;
    e_strb = s;
    if (e_port < 0) begin
      e_lat = 2; e_err = 1'b1; e_rdata = '0;
    end else if (wait_cfg[e_port] >= TMO) begin
      e_lat = 2 + TMO; e_err = 1'b1; e_rdata = '0;
    end else begin
      e_lat = 3 + wait_cfg[e_port]; e_err = err_cfg[e_port]; e_rdata = w ? 32'h0 : rd_val[e_port];
    end
    s_PSEL = 1; s_PENABLE = 0; s_PADDR = a; s_PWRITE = w; s_PWDATA = d; s_PSTRB = s;
    @(posedge PCLK); #1;
    t0 = cyc - 1;
    active = 1;
    s_PENABLE = 1; s_PADDR = $urandom; s_PWDATA = $urandom; s_PWRITE = 1'($urandom); s_PSTRB = 4'($urandom);
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge PCLK);
      if (s_PREADY) begin
        seen = 1; obs_lat = cyc - t0; obs_rdata = s_PRDATA; obs_err = s_PSLVERR;
      end
    end
    if (!seen) chk("xfer_timeout", 1'b0, 1'b1);
    @(posedge PCLK); #1;
    active = 0; s_PSEL = 0; s_PENABLE = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int k = 0; k < 4; k++) begin wait_cfg[k] = 0; rd_val[k] = '0; end
    #12;
    chk("rst_psel", m_PSEL, 4'b0);
    chk("rst_pready", s_PREADY, 1'b0);
    chk("rst_paddr", m_PADDR, 32'h0);
    @(posedge PCLK); #1;
    PRESET = 0;
    mon_en = 1;
    do_xfer(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF);
    chk("t1_lat", obs_lat, 3);
    chk("t1_err", obs_err, 1'b0);
    wait_cfg[2] = 3; rd_val[2] = 32'h1234_5678;
    do_xfer(32'h0000_3010, 1'b0, 32'h0, 4'h0);
    chk("t2_lat", obs_lat, 6);
    chk("t2_rdata", obs_rdata, 32'h1234_5678);
    do_xfer(32'hFFFF_0000, 1'b0, 32'h0, 4'h0);
    chk("t3_lat", obs_lat, 2);
    chk("t3_err", obs_err, 1'b1);
    chk("t3_rdata", obs_rdata, 32'h0);
    wait_cfg[0] = 255; rd_val[0] = 32'hA5A5_A5A5;
    do_xfer(32'h0000_2100, 1'b0, 32'h0, 4'h0);
    chk("t4_lat", obs_lat, 18);
    chk("t4_err", obs_err, 1'b1);
    chk("t4_rdata", obs_rdata, 32'h0);
    wait_cfg[0] = 0; err_cfg = 4'b0001;
    do_xfer(32'h0000_2000, 1'b0, 32'h0, 4'h0);
    chk("t5_lat", obs_lat, 3);
    chk("t5_err", obs_err, 1'b1);
    chk("t5_rdata", obs_rdata, 32'hA5A5_A5A5);
    // Async reset in ACCESS against a hung port 0.
    mon_en = 0; err_cfg = '0; wait_cfg[0] = 255;
    s_PSEL = 1; s_PENABLE = 0; s_PADDR = 32'h2040; s_PWRITE = 1; s_PWDATA = 32'h5555_AAAA; s_PSTRB = 4'h3;
    @(posedge PCLK); #1;
    s_PENABLE = 1;
    for (int i = 0; i < 4 && !m_PENABLE; i++) @(negedge PCLK);
    chk("rst_in_access", m_PSEL, 4'b0001);
    #2 PRESET = 1;
    #1;
    chk("arst_psel", m_PSEL, 4'b0);
    chk("arst_penable", m_PENABLE, 1'b0);
    chk("arst_paddr", m_PADDR, 32'h0);
    chk("arst_pwdata", m_PWDATA, 32'h0);
    chk("arst_pwrite", m_PWRITE, 1'b0);
    chk("arst_pstrb", m_PSTRB, 4'h0);
    chk("arst_pready", s_PREADY, 1'b0);
    s_PSEL = 0; s_PENABLE = 0;
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESET = 0;
    wait_cfg[0] = 1;
    mon_en = 1;
    do_xfer(32'h0000_2040, 1'b0, 32'h0, 4'h0);
    chk("post_rst_lat", obs_lat, 4);
    chk("post_rst_rdata", obs_rdata, 32'hA5A5_A5A5);
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      for (int k = 0; k < 4; k++) begin
        wait_cfg[k] = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 4));
        rd_val[k] = $urandom;
      end
      err_cfg = 4'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0: a = {a[31:16], 4'h1, a[11:0]};
        1: a = {a[31:16], 8'h20, a[7:0]};
        2: a = {a[31:16], 4'h2, a[11:0]};
        3: a = {a[31:16], 4'h3, a[11:0]};
        4: a = {16'hFFFF, 4'hF, a[11:0]};
        default: ;
      endcase
      do_xfer(a, 1'($urandom), $urandom, 4'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
